// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: round-robin writeback arbiter feeding the LC-3 register file write port.
// One grant per cycle; the winner is registered and presented on ld_reg for exactly one cycle.
module reg_wb_arbiter #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid_i,
    output logic [NREQ-1:0]          req_ready_o,
    input  logic [3*NREQ-1:0]        req_dr_i,
    input  logic [DATA_W*NREQ-1:0]   req_data_i,
    input  logic                     wb_hold_i,
    output logic                     ld_reg_o,
    output logic [2:0]               dr_addr_o,
    output logic [DATA_W-1:0]        from_bus_o,
    output logic [2:0]               wb_grant_id_o,
    output logic [15:0]              wb_count_o
);
    logic [2:0]        ptr_q, ptr_d, win, dr_q, dr_d, gid_q, gid_d;
    logic [DATA_W-1:0] bus_q, bus_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              ld_q, found;

    // Two passes give the wrap-around search: indices >= ptr first, then the rest.
    always_comb begin
        found       = 1'b0;
        win         = '0;
        req_ready_o = '0;
        dr_d        = dr_q;
        bus_d       = bus_q;
        if (!reset && !wb_hold_i) begin
            for (int i = 0; i < NREQ; i++)
                if (!found && req_valid_i[i] && 3'(i) >= ptr_q) begin
                    found = 1'b1;
                    win   = 3'(i);
                end
            for (int i = 0; i < NREQ; i++)
                if (!found && req_valid_i[i]) begin
                    found = 1'b1;
                    win   = 3'(i);
                end
        end
        for (int i = 0; i < NREQ; i++) begin
            req_ready_o[i] = found && win == 3'(i);
            if (req_ready_o[i]) begin
                dr_d  = req_dr_i[3*i +: 3];
                bus_d = req_data_i[DATA_W*i +: DATA_W];
            end
        end
        gid_d = found ? win : gid_q;
        ptr_d = found ? (win == 3'(NREQ-1) ? 3'd0 : win + 3'd1) : ptr_q;
        cnt_d = (ld_q && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
            ld_q  <= 1'b0;
            dr_q  <= '0;
            bus_q <= '0;
            gid_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            ld_q  <= found;
            dr_q  <= dr_d;
            bus_q <= bus_d;
            gid_q <= gid_d;
            cnt_q <= cnt_d;
        end
    end

    assign ld_reg_o      = ld_q;
    assign dr_addr_o     = dr_q;
    assign from_bus_o    = bus_q;
    assign wb_grant_id_o = gid_q;
    assign wb_count_o    = cnt_q;
endmodule
